wrr_vc_scheduler: RTL and testbench
===================================

// Module: wrr_vc_scheduler
// PURPOSE
//  Weighted round-robin scheduler for 4 virtual channels; generates VC_id for the
//  downstream 4:1 data mux (mux4_1_cond) of the wrr datapath.
//  Grants each requesting VC up to weight[i] consecutive transfers, then rotates.
//  Valid/ready handshake toward the consumer; one transfer per accepted cycle.
// PARAMETERS
//  NUM_VC    4  number of virtual channels (fixed at 4; VC_id is 2 bits)
//  WEIGHT_W  4  width of each per-VC weight / credit counter
// PORTS
//  clk        in   1           single clock, rising edge
//  reset      in   1           asynchronous, active-high reset
//  req        in   4           req[i]=1: VC i has data to send
//  weights    in   4*WEIGHT_W  weight of VC i at [i*WEIGHT_W +: WEIGHT_W]
//  vc_ready   in   1           consumer accepts current transfer this cycle
//  vc_valid   out  1           VC_id is a valid grant this cycle
//  VC_id      out  2           selected VC; drives mux select lines
//  grant_cnt  out  4*16        per-VC accepted-transfer counters (WRR_GRANT_CNT_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE, VC_id=0, vc_valid=0, ptr=0, credit=0, grant_cnt=0.
//  - Eligible VC: req[i]=1 and weights[i]!=0. Weight 0 masks VC (never granted).
//  - Selection: first eligible VC scanning ptr, ptr+1, ... mod 4 (wraps 3->0).
//  - FSM IDLE: if any eligible -> register VC_id=sel, credit=weights[sel], ptr=sel,
//    go SERVE (1-cycle latency from req to vc_valid). Else stay IDLE.
//  - FSM SERVE: vc_valid = req[VC_id] (combinational from registered VC_id).
//    Handshake = vc_valid & vc_ready.
//    * handshake, credit>1: credit-1, keep VC_id.
//    * handshake, credit==1: rescan from VC_id+1 (may re-pick same VC if it is
//      the only eligible one); found -> load new VC_id/credit, stay SERVE;
//      none -> IDLE.
//    * req[VC_id]=0: remaining credit forfeited; rescan from VC_id+1 same as above.
//    * vc_ready=0 with req held: hold VC_id and credit (no loss).
//  - Weights sampled only on credit load; mid-burst changes take effect next turn.
//  - VC_id stable while vc_valid=1 and vc_ready=0 (handshake rule).
//  - Reset mid-burst: immediate return to reset values, ptr restarts at 0.
//  - Credit decrement never underflows; credit==0 never observed in SERVE.
// CONFIGURATION
//  WRR_GRANT_CNT_EN defined: grant_cnt present; counter i +1 per handshake on VC i,
//    saturating at 16'hFFFF, cleared only by reset.
//  Not defined: grant_cnt port and counters absent; scheduling identical.
// STRUCTURE
//  Shared package/include wrr_pkg: NUM_VC, VC_ID_W=2, state encoding
//    (ST_IDLE=1'b0, ST_SERVE=1'b1), GRANT_CNT_W=16.
//  One sub-module: wrr_rr_pick (comb.; req mask + ptr -> sel, found).
//  Top holds FSM, credit counter, ptr, optional grant counters.
// TESTING
//  1 req=4'b1111, weights={1,2,3,4} (VC3..VC0), ready=1 -> VC_id sequence
//    0,0,0,0,1,1,1,2,2,3 then repeats; vc_valid held 1.
//  2 req=4'b0100 only, weight2=3, ready=1 -> VC_id=2 continuously, credit reloads
//    every 3 beats, no valid gap.
//  3 req=4'b0011, weights=2, ready low 5 cycles mid-burst on VC0 -> VC_id stays 0,
//    after ready returns exactly 1 more beat on VC0, then VC1.
//  4 VC1 drops req after 1 of 4 beats -> next cycle VC_id=2 (if eligible),
//    VC1 credit forfeited; weight1=0 with req1=1 -> VC1 never granted.
//  5 reset asserted mid-burst on VC2 -> same cycle vc_valid=0, VC_id=0;
//    after release with req=4'b1111 first grant is VC0.
//  6 WRR_GRANT_CNT_EN: 10 beats of scenario 1 -> grant_cnt={1,2,3,4};
//    force 70000 beats on VC0 -> grant_cnt[0]=16'hFFFF.

Source files
------------

// File: rtl/wrr_pkg.sv
// Shared constants and state encoding for the weighted round-robin VC scheduler.
// Imported by wrr_rr_pick, wrr_vc_scheduler_if and wrr_vc_scheduler.
package wrr_pkg;

  localparam int NUM_VC      = 4;
  localparam int VC_ID_W     = 2;
  localparam int GRANT_CNT_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  function automatic logic [VC_ID_W-1:0] next_vc(input logic [VC_ID_W-1:0] vc);
    return VC_ID_W'(vc + VC_ID_W'(1));
  endfunction

endpackage

// File: rtl/wrr_vc_scheduler_if.sv
// Request/weight/handshake bundle between the VC sources, scheduler and consumer.
// grant_cnt exists only when WRR_GRANT_CNT_EN is defined.
interface wrr_vc_scheduler_if #(
  parameter int WEIGHT_W = 4
);
  import wrr_pkg::*;

  logic [NUM_VC-1:0]          req;
  logic [NUM_VC*WEIGHT_W-1:0] weights;
  logic                       vc_ready;
  logic                       vc_valid;
  logic [VC_ID_W-1:0]         VC_id;

`ifdef WRR_GRANT_CNT_EN
  logic [NUM_VC*GRANT_CNT_W-1:0] grant_cnt;

  modport master (output req, weights, vc_ready, input vc_valid, VC_id, grant_cnt);
  modport slave  (input req, weights, vc_ready, output vc_valid, VC_id, grant_cnt);
`else
  modport master (output req, weights, vc_ready, input vc_valid, VC_id);
  modport slave  (input req, weights, vc_ready, output vc_valid, VC_id);
`endif

endinterface

// File: rtl/wrr_rr_pick.sv
// Combinational rotating picker: first set bit of mask scanning start, start+1, ... mod NUM_VC.
module wrr_rr_pick
  import wrr_pkg::*;
(
  input  logic [NUM_VC-1:0]  mask,
  input  logic [VC_ID_W-1:0] start,
  output logic [VC_ID_W-1:0] sel,
  output logic               found
);

  logic [VC_ID_W-1:0] idx;

  // Scan farthest offset first so the nearest hit is the last one assigned.
  always_comb begin
    sel   = start;
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      idx = VC_ID_W'(start + VC_ID_W'(i));
      if (mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_vc_scheduler.sv
// Weighted round-robin scheduler for 4 VCs; drives VC_id of the downstream 4:1 data mux.
// Optional per-VC accepted-transfer counters under macro WRR_GRANT_CNT_EN.
module wrr_vc_scheduler
  import wrr_pkg::*;
#(
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  wrr_vc_scheduler_if.slave   bus
);

  state_e               state_q, state_d;
  logic [VC_ID_W-1:0]   vc_id_q, vc_id_d;
  logic [VC_ID_W-1:0]   ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]  credit_q, credit_d;

  logic [NUM_VC-1:0]    elig;
  logic [VC_ID_W-1:0]   scan_start;
  logic [VC_ID_W-1:0]   sel;
  logic                 found;
  logic [WEIGHT_W-1:0]  sel_weight;
  logic                 vc_valid;
  logic                 hs;
  logic                 turn_over;

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      elig[i] = bus.req[i] && (bus.weights[i*WEIGHT_W +: WEIGHT_W] != '0);
    end
  end

  // IDLE resumes at the pointer; SERVE always moves past the VC whose turn just ended.
  assign scan_start = (state_q == ST_IDLE) ? ptr_q : next_vc(vc_id_q);

  wrr_rr_pick u_pick (
    .mask  (elig),
    .start (scan_start),
    .sel   (sel),
    .found (found)
  );

  assign sel_weight = bus.weights[int'(sel)*WEIGHT_W +: WEIGHT_W];
  assign vc_valid   = (state_q == ST_SERVE) && bus.req[vc_id_q];
  assign hs         = vc_valid && bus.vc_ready;
  assign turn_over  = !bus.req[vc_id_q] || (hs && (credit_q == WEIGHT_W'(1)));

  assign bus.vc_valid = vc_valid;
  assign bus.VC_id    = vc_id_q;

  always_comb begin
    state_d  = state_q;
    vc_id_d  = vc_id_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d  = ST_SERVE;
          vc_id_d  = sel;
          ptr_d    = sel;
          credit_d = sel_weight;
        end
      end
      ST_SERVE: begin
        if (turn_over) begin
          if (found) begin
            vc_id_d  = sel;
            ptr_d    = sel;
            credit_d = sel_weight;
          end else begin
            state_d  = ST_IDLE;
            credit_d = '0;
          end
        end else if (hs) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      vc_id_q  <= '0;
      ptr_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      vc_id_q  <= vc_id_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

`ifdef WRR_GRANT_CNT_EN
  logic [GRANT_CNT_W-1:0] cnt_q [NUM_VC];
  logic [GRANT_CNT_W-1:0] cnt_d [NUM_VC];

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hs && (vc_id_q == VC_ID_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + GRANT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_cnt_out
    assign bus.grant_cnt[g*GRANT_CNT_W +: GRANT_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_wrr_vc_scheduler.sv
// Self-checking bench for wrr_vc_scheduler: directed scenarios plus randomized traffic
// checked against a queue-free arithmetic model of the WRR rules.
module tb_wrr_vc_scheduler;
  import wrr_pkg::*;

  localparam int WW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wrr_vc_scheduler_if #(.WEIGHT_W(WW)) bus_if ();

  wrr_vc_scheduler #(.WEIGHT_W(WW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // reference model state
  bit m_busy;
  int m_vc;
  int m_cred;
  int m_ptr;
  int m_cnt [4];

  function automatic int wt(input int i);
    return int'(bus_if.weights[i*WW +: WW]);
  endfunction

  function automatic int scan(input int start);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (start + k) % 4;
      if (bus_if.req[idx] && wt(idx) != 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset;
    m_busy = 0; m_vc = 0; m_cred = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_load(input int s);
    m_busy = 1; m_vc = s; m_ptr = s; m_cred = wt(s);
  endtask

  // Advance the model by one clock using the inputs held across that edge.
  task automatic model_step;
    int s;
    bit hs;
    if (!m_busy) begin
      s = scan(m_ptr);
      if (s >= 0) model_load(s);
    end else begin
      hs = bus_if.req[m_vc] && bus_if.vc_ready;
      if (hs && m_cnt[m_vc] < 65535) m_cnt[m_vc]++;
      if (!bus_if.req[m_vc] || (hs && m_cred == 1)) begin
        s = scan((m_vc + 1) % 4);
        if (s >= 0) model_load(s);
        else m_busy = 0;
      end else if (hs) begin
        m_cred--;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    bus_if.weights = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    bus_if.req = '0;
    bus_if.vc_ready = 1'b0;
    set_w(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (bus_if.vc_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus_if.vc_valid);
    end
    checks++;
    if (bus_if.VC_id !== 2'd0) begin
      errors++; $display("FAIL reset_vc_id: got %0d want 0", bus_if.VC_id);
    end
`ifdef WRR_GRANT_CNT_EN
    checks++;
    if (bus_if.grant_cnt !== '0) begin
      errors++; $display("FAIL reset_grant_cnt: got %h want 0", bus_if.grant_cnt);
    end
`endif
    bus_if.req = 4'b1111;
    set_w(1, 1, 1, 1);
    bus_if.vc_ready = 1'b1;
    #1;
    checks++;
    if (bus_if.vc_valid !== 1'b0) begin
      errors++; $display("FAIL idle_latency_valid: got %b want 0", bus_if.vc_valid);
    end
    tick();
    checks++;
    if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'd0) begin
      errors++; $display("FAIL first_grant: got valid=%b vc=%0d want valid=1 vc=0",
                         bus_if.vc_valid, bus_if.VC_id);
    end
  endtask

  task automatic test_wrr_sequence;
    int seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    do_reset();
    bus_if.req = 4'b1111;
    set_w(4, 3, 2, 1);
    bus_if.vc_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'(seq[i % 10])) begin
        errors++; $display("FAIL wrr_seq[%0d]: got valid=%b vc=%0d want valid=1 vc=%0d",
                           i, bus_if.vc_valid, bus_if.VC_id, seq[i % 10]);
      end
    end
  endtask

  task automatic test_single_vc;
    do_reset();
    bus_if.req = 4'b0100;
    set_w(1, 1, 3, 1);
    bus_if.vc_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'd2) begin
        errors++; $display("FAIL single_vc[%0d]: got valid=%b vc=%0d want valid=1 vc=2",
                           i, bus_if.vc_valid, bus_if.VC_id);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    bus_if.req = 4'b0011;
    set_w(2, 2, 2, 2);
    bus_if.vc_ready = 1'b1;
    tick();
    tick();
    bus_if.vc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b vc=%0d want valid=1 vc=0",
                           i, bus_if.vc_valid, bus_if.VC_id);
      end
      tick();
    end
    bus_if.vc_ready = 1'b1;
    #1;
    checks++;
    if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'd0) begin
      errors++; $display("FAIL bp_last_beat: got vc=%0d want 0", bus_if.VC_id);
    end
    tick();
    checks++;
    if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'd1) begin
      errors++; $display("FAIL bp_rotate: got valid=%b vc=%0d want valid=1 vc=1",
                         bus_if.vc_valid, bus_if.VC_id);
    end
  endtask

  task automatic test_forfeit_and_mask;
    int seq [3] = '{0, 2, 3};
    do_reset();
    bus_if.req = 4'b0110;
    set_w(1, 4, 2, 1);
    bus_if.vc_ready = 1'b1;
    tick();
    checks++;
    if (bus_if.VC_id !== 2'd1 || bus_if.vc_valid !== 1'b1) begin
      errors++; $display("FAIL forfeit_start: got vc=%0d want 1", bus_if.VC_id);
    end
    tick();
    bus_if.req = 4'b0100;
    #1;
    checks++;
    if (bus_if.vc_valid !== 1'b0) begin
      errors++; $display("FAIL forfeit_drop_valid: got %b want 0", bus_if.vc_valid);
    end
    tick();
    checks++;
    if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'd2) begin
      errors++; $display("FAIL forfeit_next: got valid=%b vc=%0d want valid=1 vc=2",
                         bus_if.vc_valid, bus_if.VC_id);
    end
    do_reset();
    bus_if.req = 4'b1111;
    set_w(1, 0, 1, 1);
    bus_if.vc_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'(seq[i % 3])) begin
        errors++; $display("FAIL mask_w0[%0d]: got vc=%0d want %0d",
                           i, bus_if.VC_id, seq[i % 3]);
      end
    end
  endtask

  task automatic test_reset_midburst;
    do_reset();
    bus_if.req = 4'b0100;
    set_w(4, 4, 4, 4);
    bus_if.vc_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus_if.vc_valid !== 1'b0 || bus_if.VC_id !== 2'd0) begin
      errors++; $display("FAIL reset_mid: got valid=%b vc=%0d want valid=0 vc=0",
                         bus_if.vc_valid, bus_if.VC_id);
    end
    #2;
    reset = 1'b0;
    bus_if.req = 4'b1111;
    set_w(2, 2, 2, 2);
    tick();
    checks++;
    if (bus_if.vc_valid !== 1'b1 || bus_if.VC_id !== 2'd0) begin
      errors++; $display("FAIL reset_mid_restart: got valid=%b vc=%0d want valid=1 vc=0",
                         bus_if.vc_valid, bus_if.VC_id);
    end
  endtask

  task automatic test_random;
    bit exp_valid;
    do_reset();
    set_w(2, 1, 3, 2);
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) bus_if.req[i] = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) begin
        set_w($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end
      bus_if.vc_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_valid = m_busy && bus_if.req[m_vc];
      checks++;
      if (bus_if.vc_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", n, bus_if.vc_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus_if.VC_id !== 2'(m_vc)) begin
          errors++; $display("FAIL rand_vc[%0d]: got %0d want %0d", n, bus_if.VC_id, m_vc);
        end
      end
      tick();
      model_step();
    end
`ifdef WRR_GRANT_CNT_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(bus_if.grant_cnt[i*16 +: 16]) != m_cnt[i]) begin
        errors++; $display("FAIL rand_grant_cnt[%0d]: got %0d want %0d",
                           i, bus_if.grant_cnt[i*16 +: 16], m_cnt[i]);
      end
    end
`endif
  endtask

`ifdef WRR_GRANT_CNT_EN
  task automatic test_grant_cnt;
    int exp [4] = '{4, 3, 2, 1};
    do_reset();
    bus_if.req = 4'b1111;
    set_w(4, 3, 2, 1);
    bus_if.vc_ready = 1'b1;
    tick();
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(bus_if.grant_cnt[i*16 +: 16]) != exp[i]) begin
        errors++; $display("FAIL grant_cnt_seq[%0d]: got %0d want %0d",
                           i, bus_if.grant_cnt[i*16 +: 16], exp[i]);
      end
    end
    do_reset();
    bus_if.req = 4'b0001;
    set_w(15, 1, 1, 1);
    bus_if.vc_ready = 1'b1;
    tick();
    repeat (70000) tick();
    checks++;
    if (bus_if.grant_cnt[15:0] !== 16'hFFFF) begin
      errors++; $display("FAIL grant_cnt_sat: got %h want ffff", bus_if.grant_cnt[15:0]);
    end
    checks++;
    if (bus_if.grant_cnt[63:16] !== '0) begin
      errors++; $display("FAIL grant_cnt_others: got %h want 0", bus_if.grant_cnt[63:16]);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus_if.req = '0;
    bus_if.weights = '0;
    bus_if.vc_ready = 1'b0;
    test_reset();
    test_wrr_sequence();
    test_single_vc();
    test_backpressure();
    test_forfeit_and_mask();
    test_reset_midburst();
    test_random();
`ifdef WRR_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
